rec_df_bank_ctrl: RTL
=====================

REC_DF_BANK_CTRL -- requirements
Module: rec_DF_bank_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: pixel word width (four 8-bit samples).
REQ-002 SHALL provide parameter BLK_NUM, default 24: 4x4 blocks per macroblock (16 luma + 8 chroma).
REQ-003 SHALL provide parameter WORDS_PER_BLK, default 4: words per 4x4 block.
REQ-004 SHALL provide parameter NUM_BANKS, default 2, legal 2..4: single-port SRAM banks in rotation.
REQ-005 SHALL derive localparam ADDR_W = clog2(BLK_NUM*WORDS_PER_BLK), 7 at defaults; BLK_W = clog2(BLK_NUM); OFS_W = clog2(WORDS_PER_BLK); PTR_W = clog2(NUM_BANKS).
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 disable_DF  in  1  deblocking off; writes suppressed, banks released without fill.
REQ-009 wr_en  in  1  reconstruction write strobe.
REQ-010 wr_blk  in  BLK_W  raster-order block index of write.
REQ-011 wr_ofs  in  OFS_W  word offset within block.
REQ-012 wr_data  in  DATA_W  write data.
REQ-013 wr_mb_done  in  1  one-cycle pulse; current write bank complete.
REQ-014 rd_en  in  1  DF read strobe.
REQ-015 rd_blk  in  BLK_W  block index of read.
REQ-016 rd_ofs  in  OFS_W  word offset of read.
REQ-017 rd_mb_done  in  1  one-cycle pulse; current read bank consumed.
REQ-018 wr_ready  out  1  a free bank is available for writing.
REQ-019 rd_ready  out  1  a filled bank is available for reading.
REQ-020 rd_dout  out  DATA_W  read data, registered.
REQ-021 rd_valid  out  1  rd_dout valid.
REQ-022 err  out  1  sticky protocol-error flag.
REQ-023 ram_wr / ram_rd  out  NUM_BANKS  per-bank strobes, bit i = bank i.
REQ-024 ram_addr  out  NUM_BANKS*ADDR_W  per-bank address, flattened, bank 0 in LSBs.
REQ-025 ram_din  out  DATA_W  write data, shared by all banks.
REQ-026 ram_dout  in  NUM_BANKS*DATA_W  per-bank read data, one-cycle SRAM latency.

Function
REQ-027 Address SHALL be blk*WORDS_PER_BLK + ofs, zero-extended to ADDR_W.
REQ-028 Write pointer wp, read pointer rp (PTR_W each) SHALL increment modulo NUM_BANKS on wr_mb_done / rd_mb_done respectively.
REQ-029 Counter full_cnt (0..NUM_BANKS) SHALL +1 on wr_mb_done alone, -1 on rd_mb_done alone, hold when both pulse in the same cycle.
REQ-030 wr_ready SHALL equal (full_cnt < NUM_BANKS); rd_ready SHALL equal (full_cnt > 0); both combinational from registers.
REQ-031 An accepted write (wr_en & wr_ready & !disable_DF & wr_blk<BLK_NUM) SHALL drive ram_wr[wp]=1, ram_addr slice wp = write address, ram_din = wr_data, same cycle.
REQ-032 An accepted read (rd_en & rd_ready & rd_blk<BLK_NUM) SHALL drive ram_rd[rp]=1 and ram_addr slice rp = read address, same cycle.
REQ-033 Since wp!=rp whenever both wr_ready and rd_ready are high, write and read SHALL never hit the same bank; when wp==rp only one of wr_ready/rd_ready is high.
REQ-034 Unselected bank strobes SHALL be 0, unselected addresses 0, ram_din 0 when no write accepted.
REQ-035 rd_valid SHALL assert exactly one cycle after an accepted read; rd_dout SHALL register ram_dout of the bank latched at read time (pointer change in between has no effect).
REQ-036 With disable_DF=1, writes SHALL be dropped; wr_mb_done SHALL NOT change wp or full_cnt.
REQ-037 err SHALL set on: wr_en with !wr_ready; rd_en with !rd_ready; wr_mb_done with full_cnt==NUM_BANKS (not simultaneous with rd_mb_done); rd_mb_done with full_cnt==0; block index >= BLK_NUM. Offending event otherwise ignored; err clears only by reset.

Reset
REQ-038 reset_n low SHALL asynchronously force wp=rp=0, full_cnt=0, rd_valid=0, rd_dout=0, err=0; hence wr_ready=1, rd_ready=0, all ram strobes 0.
REQ-039 Reset mid-macroblock SHALL discard bank contents logically; no SRAM clearing required.

Structure
REQ-040 Defaults for DATA_W, BLK_NUM, WORDS_PER_BLK, NUM_BANKS SHALL live in a shared package alongside the existing nova defines.
REQ-041 One sub-module rec_DF_bank_ptr (pointer + full_cnt + ready logic) SHALL be instantiated; datapath muxing stays in the top.

Verification
REQ-042 Reset, write blk 5 ofs 2 data 0xA1B2C3D4 -> ram_wr=01, bank0 addr 22, din 0xA1B2C3D4.
REQ-043 NUM_BANKS=2: two wr_mb_done without reads -> full_cnt 2, wr_ready=0; third wr_en -> no strobe, err=1.
REQ-044 Bank0 filled, rd blk 3 ofs 1 while writing bank1 -> ram_rd=01 addr 13, ram_wr=10; rd_valid next cycle with bank0 data.
REQ-045 full_cnt=1, wr_mb_done and rd_mb_done same cycle -> full_cnt stays 1, wp and rp both advance, err=0.
REQ-046 disable_DF=1, wr_en + wr_mb_done -> no ram_wr, wp unchanged, rd_ready stays 0.
REQ-047 NUM_BANKS=3: fill 3, drain 3 with interleaving -> pointers wrap 2->0, no err, every read returns the data written to its bank.

Source files
------------

// File: rtl/rec_df_bank_ctrl_pkg.sv
// Shared nova defaults and types for the reconstruction/deblocking bank controller.
package rec_df_bank_ctrl_pkg;

  localparam int NOVA_PIX_W         = 8;
  localparam int NOVA_DATA_W        = 4 * NOVA_PIX_W;
  localparam int NOVA_LUMA_BLKS     = 16;
  localparam int NOVA_CHROMA_BLKS   = 8;
  localparam int NOVA_BLK_NUM       = NOVA_LUMA_BLKS + NOVA_CHROMA_BLKS;
  localparam int NOVA_WORDS_PER_BLK = 4;
  localparam int NOVA_NUM_BANKS     = 2;

  // Individual protocol-error sources; any one of them sets the sticky flag.
  typedef struct packed {
    logic wr_no_bank;
    logic rd_no_bank;
    logic wr_done_ovf;
    logic rd_done_unf;
    logic bad_blk;
  } df_err_t;

endpackage

// File: rtl/rec_df_bank_ctrl_ptr.sv
// Bank rotation bookkeeping: write/read pointers, filled-bank count and ready flags.
module rec_df_bank_ptr
  import rec_df_bank_ctrl_pkg::*;
#(
  parameter int  NUM_BANKS = NOVA_NUM_BANKS,
  localparam int PTR_W     = $clog2(NUM_BANKS),
  localparam int CNT_W     = $clog2(NUM_BANKS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_done_i,
  input  logic             rd_done_i,
  output logic [PTR_W-1:0] wp_o,
  output logic [PTR_W-1:0] rp_o,
  output logic             wr_ready_o,
  output logic             rd_ready_o,
  output logic             wr_done_err_o,
  output logic             rd_done_err_o
);

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] full_cnt_q, full_cnt_d;
  logic             wr_done_ok;
  logic             rd_done_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_BANKS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_ready_o = (full_cnt_q < CNT_W'(NUM_BANKS));
  assign rd_ready_o = (full_cnt_q != '0);

  // A release on a full set still lets a same-cycle completion through.
  assign rd_done_ok    = rd_done_i & rd_ready_o;
  assign wr_done_ok    = wr_done_i & (wr_ready_o | rd_done_ok);
  assign wr_done_err_o = wr_done_i & ~wr_done_ok;
  assign rd_done_err_o = rd_done_i & ~rd_done_ok;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    full_cnt_d = full_cnt_q;
    if (wr_done_ok) wp_d = ptr_inc(wp_q);
    if (rd_done_ok) rp_d = ptr_inc(rp_q);
    case ({wr_done_ok, rd_done_ok})
      2'b10:   full_cnt_d = full_cnt_q + CNT_W'(1);
      2'b01:   full_cnt_d = full_cnt_q - CNT_W'(1);
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      full_cnt_q <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      full_cnt_q <= full_cnt_d;
    end
  end

  assign wp_o = wp_q;
  assign rp_o = rp_q;

endmodule

// File: rtl/rec_df_bank_ctrl.sv
// Rotating single-port SRAM bank controller between reconstruction (writer) and deblocking (reader).
module rec_df_bank_ctrl
  import rec_df_bank_ctrl_pkg::*;
#(
  parameter int  DATA_W        = NOVA_DATA_W,
  parameter int  BLK_NUM       = NOVA_BLK_NUM,
  parameter int  WORDS_PER_BLK = NOVA_WORDS_PER_BLK,
  parameter int  NUM_BANKS     = NOVA_NUM_BANKS,
  localparam int ADDR_W        = $clog2(BLK_NUM * WORDS_PER_BLK),
  localparam int BLK_W         = $clog2(BLK_NUM),
  localparam int OFS_W         = $clog2(WORDS_PER_BLK),
  localparam int PTR_W         = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        disable_df_i,
  input  logic                        wr_en_i,
  input  logic [BLK_W-1:0]            wr_blk_i,
  input  logic [OFS_W-1:0]            wr_ofs_i,
  input  logic [DATA_W-1:0]           wr_data_i,
  input  logic                        wr_mb_done_i,
  input  logic                        rd_en_i,
  input  logic [BLK_W-1:0]            rd_blk_i,
  input  logic [OFS_W-1:0]            rd_ofs_i,
  input  logic                        rd_mb_done_i,
  output logic                        wr_ready_o,
  output logic                        rd_ready_o,
  output logic [DATA_W-1:0]           rd_dout_o,
  output logic                        rd_valid_o,
  output logic                        err_o,
  output logic [NUM_BANKS-1:0]        ram_wr_o,
  output logic [NUM_BANKS-1:0]        ram_rd_o,
  output logic [NUM_BANKS*ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0]           ram_din_o,
  input  logic [NUM_BANKS*DATA_W-1:0] ram_dout_i
);

  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic              wr_done_err;
  logic              rd_done_err;
  logic              wr_blk_ok;
  logic              rd_blk_ok;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  df_err_t           err_src;

  logic              err_q;
  logic              rd_valid_q;
  logic [PTR_W-1:0]  rd_bank_q;

  // With deblocking off, completions are swallowed so no bank is ever handed to the reader.
  rec_df_bank_ptr #(
    .NUM_BANKS (NUM_BANKS)
  ) u_ptr (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_done_i     (wr_mb_done_i & ~disable_df_i),
    .rd_done_i     (rd_mb_done_i),
    .wp_o          (wp),
    .rp_o          (rp),
    .wr_ready_o    (wr_ready_o),
    .rd_ready_o    (rd_ready_o),
    .wr_done_err_o (wr_done_err),
    .rd_done_err_o (rd_done_err)
  );

  // Compare in 32 bits so a power-of-two BLK_NUM does not wrap the bound.
  assign wr_blk_ok = (int'(wr_blk_i) < BLK_NUM);
  assign rd_blk_ok = (int'(rd_blk_i) < BLK_NUM);

  assign wr_acc = wr_en_i & wr_ready_o & ~disable_df_i & wr_blk_ok;
  assign rd_acc = rd_en_i & rd_ready_o & rd_blk_ok;

  assign wr_addr = ADDR_W'(wr_blk_i) * ADDR_W'(WORDS_PER_BLK) + ADDR_W'(wr_ofs_i);
  assign rd_addr = ADDR_W'(rd_blk_i) * ADDR_W'(WORDS_PER_BLK) + ADDR_W'(rd_ofs_i);

  // wp and rp never coincide while both sides are ready, so the two slices never collide.
  always_comb begin
    ram_wr_o   = '0;
    ram_rd_o   = '0;
    ram_addr_o = '0;
    ram_din_o  = '0;
    if (wr_acc) begin
      ram_wr_o[wp]                             = 1'b1;
      ram_addr_o[int'(wp) * ADDR_W +: ADDR_W] = wr_addr;
      ram_din_o                                = wr_data_i;
    end
    if (rd_acc) begin
      ram_rd_o[rp]                             = 1'b1;
      ram_addr_o[int'(rp) * ADDR_W +: ADDR_W] = rd_addr;
    end
  end

  assign err_src.wr_no_bank  = wr_en_i & ~wr_ready_o;
  assign err_src.rd_no_bank  = rd_en_i & ~rd_ready_o;
  assign err_src.wr_done_ovf = wr_done_err;
  assign err_src.rd_done_unf = rd_done_err;
  assign err_src.bad_blk     = (wr_en_i & ~wr_blk_ok) | (rd_en_i & ~rd_blk_ok);

  // The bank is captured at issue so a same-cycle rd_mb_done cannot redirect the data mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      err_q      <= err_q | (|err_src);
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_bank_q <= rp;
    end
  end

  // NOTE: the SRAM arrays are never cleared on reset; the pointers alone decide what is valid.
  // The SRAM output register is the storage stage, so the read word is simply steered here.
  assign rd_dout_o  = rd_valid_q ? ram_dout_i[int'(rd_bank_q) * DATA_W +: DATA_W] : '0;
  assign rd_valid_o = rd_valid_q;
  assign err_o      = err_q;

endmodule
